des_stream_controller: RTL



---
 rtl/des_stream_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/des_stream_controller.sv
// Byte-stream wrapper around a combinational DES core. It collects eight bytes into one block,
// holds the block stable while the core settles, then sends the result out as eight bytes.
module des_stream_controller #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt_in,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] core_in,
  output logic [63:0] core_key,
  output logic        core_decrypt,
  input  logic [63:0] core_out,
  output logic        busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("des_stream_controller: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, SETTLE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [63:0] block_q, block_d;
  logic [63:0] key_q, key_d;
  logic [63:0] out_q, out_d;
  logic        mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      byte_cnt_q   <= 3'd0;
      settle_cnt_q <= 4'd0;
      block_q      <= 64'd0;
      key_q        <= 64'd0;
      out_q        <= 64'd0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      block_q      <= block_d;
      key_q        <= key_d;
      out_q        <= out_d;
      mode_q       <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    block_d      = block_q;
    key_d        = key_q;
    out_d        = out_q;
    mode_d       = mode_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (key_load) key_d = key_in;
        if (in_valid) begin
          block_d = {block_q[55:0], in_byte};
          if (byte_cnt_q == 3'd0) mode_d = decrypt_in;
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d   = 3'd0;
            settle_cnt_d = 4'd0;
            state_d      = SETTLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      SETTLE: begin
        // Core inputs and key are frozen here; a key_load now is simply dropped.
        busy         = 1'b1;
        settle_cnt_d = settle_cnt_q + 4'd1;
        if (settle_cnt_q == SETTLE_LAST) begin
          out_d   = core_out;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (key_load) key_d = key_in;
        if (out_ready) begin
          out_d = {out_q[55:0], 8'h00};
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d = 3'd0;
            state_d    = COLLECT;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign out_byte     = out_q[63:56];
  assign core_in      = block_q;
  assign core_key     = key_q;
  assign core_decrypt = mode_q;

endmodule
